// File: rtl/store_merge_unit.sv
// Store merge unit: turns byte-addressed MIPS stores (SB/SH/SW/SWL/SWR) into full-word memory writes.
// Latency: direct write START->DONE in 2 cycles, read-modify-write in 3+RD_LATENCY cycles.
// Backpressure: BUSY is high outside IDLE and START is ignored while busy (no queueing).
// Optional: define STORE_ALIGN_TRAP_EN to trap misaligned SH/SW (STORE_ERROR with no memory access).
module store_merge_unit #(
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [5:0]            OP_CODE,
  input  logic [31:0]           TARGET_MEM_ADDR,
  input  logic [31:0]           STORE_DATA,
  input  logic [31:0]           MEM_DATA_READ,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [31:0]           MEM_DATA_WRITE,
  output logic                  MEM_RE,
  output logic                  MEM_WE,
  output logic [3:0]            BYTE_ENABLE,
  output logic                  BUSY,
  output logic                  STORE_DONE,
  output logic                  STORE_ERROR
);

  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  // WAIT counts down from RD_LATENCY-1 so the last WAIT cycle is the one with count 0
  localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t                state_q;
  logic [2:0]            cnt_q;
  logic [3:0]            lanes_q;
  logic [31:0]           data_q;
  logic [31:0]           rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  re_q, we_q, busy_q, done_q, err_q;

  logic [1:0]            a;
  logic                  is_store_d, trap_d;
  logic [3:0]            lanes_d;
  logic [31:0]           data_d;
  logic [ADDR_WIDTH-1:0] word_d;
  logic [31:0]           wmask;

  // Byte address bits above the word index are intentionally ignored
  logic unused_addr_hi;
  assign unused_addr_hi = ^TARGET_MEM_ADDR[31:ADDR_WIDTH+2];

  // Decode the request: which lanes change and STORE_DATA moved into those lanes
  always_comb begin
    a          = TARGET_MEM_ADDR[1:0];
    word_d     = TARGET_MEM_ADDR[ADDR_WIDTH+1:2];
    is_store_d = 1'b1;
    trap_d     = 1'b0;
    lanes_d    = 4'b0000;
    data_d     = 32'h0;
    case (OP_CODE)
      OP_SB: begin
        lanes_d = 4'b0001 << a;
        data_d  = STORE_DATA << {a, 3'b000};
      end
      OP_SH: begin
`ifdef STORE_ALIGN_TRAP_EN
        trap_d  = a[0];
`endif
        lanes_d = a[1] ? 4'b1100 : 4'b0011;
        data_d  = a[1] ? {STORE_DATA[15:0], 16'h0} : {16'h0, STORE_DATA[15:0]};
      end
      OP_SW: begin
`ifdef STORE_ALIGN_TRAP_EN
        trap_d  = (a != 2'b00);
`endif
        lanes_d = 4'b1111;
        data_d  = STORE_DATA;
      end
      OP_SWL: begin
        // lanes 0..a receive the most significant bytes of the register
        lanes_d = 4'b1111 >> (~a);
        data_d  = STORE_DATA >> {~a, 3'b000};
      end
      OP_SWR: begin
        // lanes a..3 receive the least significant bytes of the register
        lanes_d = 4'b1111 << a;
        data_d  = STORE_DATA << {a, 3'b000};
      end
      default: is_store_d = 1'b0;
    endcase
  end

  // Store sequencer: IDLE -> [READ -> WAIT*] -> WRITE -> DONE, strobes registered per state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      lanes_q <= 4'b0000;
      data_q  <= 32'h0;
      rd_q    <= 32'h0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      re_q   <= 1'b0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START && is_store_d) begin
            lanes_q <= lanes_d;
            data_q  <= data_d;
            busy_q  <= 1'b1;
            if (trap_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (lanes_d == 4'b1111) begin
              state_q <= S_WRITE;
              we_q    <= 1'b1;
              addr_q  <= word_d;
            end else begin
              state_q <= S_READ;
              re_q    <= 1'b1;
              addr_q  <= word_d;
            end
          end
        end
        S_READ: begin
          state_q <= S_WAIT;
          cnt_q   <= CNT_INIT;
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            rd_q    <= MEM_DATA_READ;
            state_q <= S_WRITE;
            we_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_WRITE: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          addr_q  <= '0;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Untouched lanes keep the captured read word; a full-word store overwrites every lane
  assign wmask = {{8{lanes_q[3]}}, {8{lanes_q[2]}}, {8{lanes_q[1]}}, {8{lanes_q[0]}}};

  assign MEM_DATA_WRITE = we_q ? ((rd_q & ~wmask) | (data_q & wmask)) : 32'h0;
  assign BYTE_ENABLE    = we_q ? lanes_q : 4'b0000;
  assign MEM_ADDRESS    = addr_q;
  assign MEM_RE         = re_q;
  assign MEM_WE         = we_q;
  assign BUSY           = busy_q;
  assign STORE_DONE     = done_q;
  assign STORE_ERROR    = err_q;

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart of the load masking path.
- Converts byte-addressed MIPS stores (SB, SH, SW, SWL, SWR) into full-word writes to the word-addressable data memory.
- Partial-word stores use a read-modify-write (RMW) sequence; full-word aligned stores write directly.
- Sits between the MEM stage and the data memory port. BUSY stalls the pipeline while a store is in flight.

Parameters:
- ADDR_WIDTH, 6: width of MEM_ADDRESS (word index). MEM_ADDRESS = TARGET_MEM_ADDR[ADDR_WIDTH+1:2]; higher address bits are ignored.
- RD_LATENCY, 1: cycles from the MEM_RE cycle to valid MEM_DATA_READ. Legal values are 1 to 4.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle store request, sampled only in IDLE.
- OP_CODE  input  6  instruction opcode: SB=0x28, SH=0x29, SWL=0x2A, SW=0x2B, SWR=0x2E.
- TARGET_MEM_ADDR  input  32  byte address.
- STORE_DATA  input  32  rt register value.
- MEM_DATA_READ  input  32  raw memory word (RMW read path).
- MEM_ADDRESS  output  ADDR_WIDTH  word address to memory.
- MEM_DATA_WRITE  output  32  merged word to memory.
- MEM_RE  output  1  memory read strobe.
- MEM_WE  output  1  memory write strobe.
- BYTE_ENABLE  output  4  lanes modified by this store (bit k = bits [8k+7:8k]).
- BUSY  output  1  high in every state except IDLE.
- STORE_DONE  output  1  one-cycle completion pulse.
- STORE_ERROR  output  1  valid only with STORE_DONE.

Behaviour:
- Reset (asynchronous): state = IDLE; all outputs 0; latched operands and the captured read word cleared.
- Little-endian lane mapping; a = TARGET_MEM_ADDR[1:0].
  - SB: lane a ← STORE_DATA[7:0].
  - SH: lanes {2a[1], 2a[1]+1} ← STORE_DATA[15:0].
  - SW: all lanes ← STORE_DATA.
  - SWL: lanes 0..a ← STORE_DATA >> 8*(3-a).
  - SWR: lanes a..3 ← STORE_DATA << 8*a.
- Merge rule: lanes outside BYTE_ENABLE keep the captured read word.
- IDLE:
  - START with a store opcode: latch OP_CODE, address and data; compute lanes.
  - If all 4 lanes are enabled (SW, SWL a=3, SWR a=0): go to WRITE.
  - Otherwise: go to READ.
  - START with a non-store opcode: ignored, remain in IDLE.
- READ (1 cycle): MEM_RE=1, MEM_ADDRESS driven. Go to WAIT.
- WAIT (RD_LATENCY cycles, down-counter): at the edge ending the last WAIT cycle, capture MEM_DATA_READ. Go to WRITE.
- WRITE (1 cycle): MEM_WE=1; MEM_DATA_WRITE = merged word; BYTE_ENABLE = lanes; MEM_ADDRESS held. Go to DONE.
- DONE (1 cycle): STORE_DONE=1. Go to IDLE.
- Strobes:
  - MEM_RE and MEM_WE are never high together.
  - MEM_DATA_WRITE and BYTE_ENABLE are 0 outside WRITE.
  - MEM_ADDRESS is 0 in IDLE.
- Latency (START accepted at edge 0):
  - Direct write: WRITE in cycle 1, DONE in cycle 2.
  - RMW: READ in cycle 1, WAIT in cycles 2..1+RD_LATENCY, WRITE in cycle 2+RD_LATENCY, DONE in cycle 3+RD_LATENCY.
- START while BUSY: ignored; no queueing.
- RESET mid-operation: immediate abort to IDLE; a write not yet in WRITE never occurs.
- OP_CODE and address changes after acceptance have no effect (operands latched).

Optional Feature:
- Macro: STORE_ALIGN_TRAP_EN.
- Defined: SH with a[0]=1, or SW with a≠0, goes IDLE→DONE directly with STORE_ERROR=1. No MEM_RE or MEM_WE is issued.
- Undefined: STORE_ERROR tied to 0. SH ignores a[0]; SW treats a as 0. The store proceeds normally.

Test Plan:
- SB: addr 0x05, data 0x000000AB, mem[1]=0x11223344 → MEM_RE cycle 1; MEM_WE cycle 3 with MEM_ADDRESS=1, data 0x1122AB44, BE=0010; STORE_DONE cycle 4 (RD_LATENCY=1).
- SH: addr 0x06, data 0x0000BEEF, mem[1]=0x11223344 → write 0xBEEF3344, BE=1100.
- SW: addr 0x08, data 0xDEADBEEF → no MEM_RE; MEM_WE cycle 1 with MEM_ADDRESS=2, BE=1111; STORE_DONE cycle 2; BUSY high cycles 1-2.
- SWL: addr 0x01 with data 0xAABBCCDD, mem=0x11223344 → write 0x1122AABB, BE=0011.
- SWR: addr 0x02 with data 0xAABBCCDD, mem=0x11223344 → write 0xCCDD3344, BE=1100.
- Assert RESET during WAIT of an SB → outputs 0 immediately, no MEM_WE follows. Misaligned SW at 0x0A:
  - With STORE_ALIGN_TRAP_EN: STORE_DONE and STORE_ERROR high in cycle 1, no strobes.
  - Without STORE_ALIGN_TRAP_EN: normal write to word 2.
